// File: rtl/esdi_pkg.sv
// ESDI command engine shared definitions.
// Holds the FSM states, the default payload width and the parity helper.
package esdi_pkg;

    localparam int CMD_BITS_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        CMD_SETUP,
        CMD_REQ,
        CMD_REL,
        STAT_REQ,
        STAT_REL,
        DONE
    } esdi_state_e;

    // Bit that makes payload plus parity carry an odd number of ones.
    function automatic logic odd_parity(input logic [63:0] v);
        return ~(^v);
    endfunction

endpackage

// File: rtl/esdi_sync.sv
// Reset-clearable multi-flop synchroniser for one asynchronous drive line.
// The output is the last stage of the chain.
module esdi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous level through the flop chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= (sync_q << 1) | STAGES'(d_i);
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/esdi_cmd_engine.sv
// ESDI serial command/status engine: sends an odd-parity command frame
// bit by bit over a REQ/ACK handshake and optionally reads a status frame.
module esdi_cmd_engine
    import esdi_pkg::*;
#(
    parameter int CMD_BITS       = CMD_BITS_DEF,
    parameter int NUM_DRIVES     = 4,
    parameter int SEL_ENCODED    = 0,
    parameter int SETUP_CYCLES   = 8,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int SYNC_STAGES    = 2,
    localparam int DRV_W = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1,
    localparam int SEL_W = (SEL_ENCODED != 0) ? DRV_W : NUM_DRIVES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [CMD_BITS-1:0] cmd_word,
    input  logic [DRV_W-1:0]    cmd_drive,
    input  logic                cmd_read_status,
    output logic                rsp_valid,
    output logic [CMD_BITS-1:0] rsp_data,
    output logic                rsp_parity_err,
    output logic                rsp_timeout,
    output logic                esdi_transfer_req,
    output logic                esdi_command_data,
    input  logic                esdi_transfer_ack,
    input  logic                esdi_confstat_data,
    output logic [SEL_W-1:0]    esdi_drive_select
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > SETUP_CYCLES) ?
                             TIMEOUT_CYCLES : SETUP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(CMD_BITS + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_TOP    = IDX_W'(CMD_BITS);

    esdi_state_e         state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [IDX_W-1:0]    idx_q;
    logic [CMD_BITS:0]   frame_q;
    logic [CMD_BITS:0]   stat_q;
    logic                rd_q;
    logic                arm_q;
    logic                req_q;
    logic                cdat_q;
    logic [SEL_W-1:0]    sel_q;
    logic                rv_q;
    logic [CMD_BITS-1:0] rdata_q;
    logic                perr_q;
    logic                tmo_q;
    logic                rdy_q;

    logic [CMD_BITS:0]   frame_d;
    logic [CMD_BITS:0]   stat_d;
    logic [SEL_W-1:0]    sel_d;
    logic                ack_s;
    logic                conf_s;
    logic                tmo_hit;

    esdi_sync #(.STAGES(SYNC_STAGES)) u_sync_ack (
        .clk (clk),
        .rst (rst),
        .d_i (esdi_transfer_ack),
        .q_o (ack_s)
    );

    esdi_sync #(.STAGES(SYNC_STAGES)) u_sync_stat (
        .clk (clk),
        .rst (rst),
        .d_i (esdi_confstat_data),
        .q_o (conf_s)
    );

    // Frame to send, select pattern and next status shift value.
    always_comb begin
        frame_d = {cmd_word, odd_parity(64'(cmd_word))};
        stat_d  = {stat_q[CMD_BITS-1:0], conf_s};
        sel_d   = '0;
        if (SEL_ENCODED != 0) begin
            sel_d = SEL_W'(cmd_drive);
        end else begin
            sel_d[cmd_drive] = 1'b1;
        end
    end

    assign tmo_hit = (cnt_q == TMO_LAST);

    // Handshake FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            frame_q <= '0;
            stat_q  <= '0;
            rd_q    <= 1'b0;
            arm_q   <= 1'b0;
            req_q   <= 1'b0;
            cdat_q  <= 1'b0;
            sel_q   <= '0;
            rv_q    <= 1'b0;
            rdata_q <= '0;
            perr_q  <= 1'b0;
            tmo_q   <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            rv_q  <= 1'b0;
            cnt_q <= cnt_q + CNT_W'(1);
            unique case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (cmd_valid && rdy_q) begin
                        frame_q <= frame_d;
                        rd_q    <= cmd_read_status;
                        sel_q   <= sel_d;
                        rdy_q   <= 1'b0;
                        state_q <= SELECT;
                    end
                end
                SELECT: begin
                    if (cnt_q == SETUP_LAST) begin
                        idx_q   <= IDX_TOP;
                        cdat_q  <= frame_q[CMD_BITS];
                        cnt_q   <= '0;
                        state_q <= CMD_SETUP;
                    end
                end
                CMD_SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        req_q   <= 1'b1;
                        arm_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= CMD_REQ;
                    end
                end
                CMD_REQ: begin
                    // A stale high ACK must be seen low before it counts.
                    if (arm_q && ack_s) begin
                        req_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= CMD_REL;
                    end else if (tmo_hit) begin
                        req_q   <= 1'b0;
                        sel_q   <= '0;
                        rv_q    <= 1'b1;
                        rdata_q <= '0;
                        perr_q  <= 1'b0;
                        tmo_q   <= 1'b1;
                        state_q <= DONE;
                    end else if (!ack_s) begin
                        arm_q <= 1'b1;
                    end
                end
                CMD_REL: begin
                    if (!ack_s) begin
                        cnt_q <= '0;
                        if (idx_q != '0) begin
                            idx_q   <= idx_q - IDX_W'(1);
                            cdat_q  <= frame_q[idx_q - IDX_W'(1)];
                            state_q <= CMD_SETUP;
                        end else if (rd_q) begin
                            idx_q   <= IDX_TOP;
                            stat_q  <= '0;
                            req_q   <= 1'b1;
                            arm_q   <= 1'b0;
                            state_q <= STAT_REQ;
                        end else begin
                            sel_q   <= '0;
                            rv_q    <= 1'b1;
                            rdata_q <= '0;
                            perr_q  <= 1'b0;
                            tmo_q   <= 1'b0;
                            state_q <= DONE;
                        end
                    end else if (tmo_hit) begin
                        sel_q   <= '0;
                        rv_q    <= 1'b1;
                        rdata_q <= '0;
                        perr_q  <= 1'b0;
                        tmo_q   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                STAT_REQ: begin
                    if (arm_q && ack_s) begin
                        stat_q  <= stat_d;
                        req_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= STAT_REL;
                    end else if (tmo_hit) begin
                        req_q   <= 1'b0;
                        sel_q   <= '0;
                        rv_q    <= 1'b1;
                        rdata_q <= '0;
                        perr_q  <= 1'b0;
                        tmo_q   <= 1'b1;
                        state_q <= DONE;
                    end else if (!ack_s) begin
                        arm_q <= 1'b1;
                    end
                end
                STAT_REL: begin
                    if (!ack_s) begin
                        cnt_q <= '0;
                        if (idx_q != '0) begin
                            idx_q   <= idx_q - IDX_W'(1);
                            req_q   <= 1'b1;
                            arm_q   <= 1'b0;
                            state_q <= STAT_REQ;
                        end else begin
                            sel_q   <= '0;
                            rv_q    <= 1'b1;
                            rdata_q <= stat_q[CMD_BITS:1];
                            perr_q  <= ~(^stat_q);
                            tmo_q   <= 1'b0;
                            state_q <= DONE;
                        end
                    end else if (tmo_hit) begin
                        sel_q   <= '0;
                        rv_q    <= 1'b1;
                        rdata_q <= '0;
                        perr_q  <= 1'b0;
                        tmo_q   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    cdat_q  <= 1'b0;
                    rdy_q   <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready         = rdy_q;
    assign rsp_valid         = rv_q;
    assign rsp_data          = rdata_q;
    assign rsp_parity_err    = perr_q;
    assign rsp_timeout       = tmo_q;
    assign esdi_transfer_req = req_q;
    assign esdi_command_data = cdat_q;
    assign esdi_drive_select = sel_q;

endmodule
